// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM encoding and FIFO word sizing for the
//               configurable UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Stored word is {ferr, perr, data}
  function automatic int fifo_width(input int dbit);
    return dbit + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_cfg_if.sv
// ============================================================================
// Module      : uart_rx_fifo_cfg_if
// Description : Consumer-side bus of the UART receiver: pop/clear controls,
//               FWFT head word and FIFO status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_fifo_cfg_if #(
  parameter int DBIT = 8,
  parameter int W    = 2
) ();

  logic            rd;
  logic            clr_ovr;
  logic [DBIT-1:0] r_data;
  logic            r_perr;
  logic            r_ferr;
  logic            empty;
  logic            full;
  logic [W:0]      count;
  logic            overrun;
  logic            break_det;

  modport master (
    output rd, clr_ovr,
    input  r_data, r_perr, r_ferr, empty, full, count, overrun, break_det
  );

  modport slave (
    input  rd, clr_ovr,
    output r_data, r_perr, r_ferr, empty, full, count, overrun, break_det
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo_cfg_fifo.sv
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Synchronous first-word-fall-through FIFO, depth 2**W, with
//               occupancy count; a read at full frees the slot for a write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_fwft #(
  parameter int WIDTH = 10,
  parameter int W     = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             wr,
  input  wire logic             rd,
  input  wire logic [WIDTH-1:0] w_data,
  output logic      [WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic      [W:0]       count
);

  localparam int DEPTH = 2**W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [W-1:0]     wptr_q, wptr_d;
  logic [W-1:0]     rptr_q, rptr_d;
  logic [W:0]       count_q, count_d;
  logic             do_rd, do_wr;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (W+1)'(DEPTH));
    do_rd   = rd & ~empty;
    do_wr   = wr & (~full | do_rd);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_wr) wptr_d = wptr_q + W'(1);
    if (do_rd) rptr_d = rptr_q + W'(1);
    if (do_wr && !do_rd)      count_d = count_q + (W+1)'(1);
    else if (do_rd && !do_wr) count_d = count_q - (W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= w_data;
  end

  assign r_data = empty ? '0 : mem_q[rptr_q];
  assign count  = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo_cfg.sv
// ============================================================================
// Module      : uart_rx_fifo_cfg
// Description : Configurable oversampling UART receiver feeding a FWFT FIFO
//               with per-word parity/framing flags, break and overrun status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DBIT  = 8,
  parameter int PMODE = 0,
  parameter int SBIT  = 1,
  parameter int OVS   = 16,
  parameter int DIV_W = 16,
  parameter int W     = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             rx,
  input  wire logic [DIV_W-1:0] baud_div,
  uart_rx_fifo_cfg_if.slave     bus
);

  localparam int FW = fifo_width(DBIT);
  localparam int SW = $clog2(OVS);

  logic rx_meta_q, rx_meta_d, rxs_q, rxs_d;
  logic [DIV_W-1:0] div_q, div_d, tcnt_q, tcnt_d, div_eff;
  logic tick;

  always_comb begin
    rx_meta_d = rx;
    rxs_d     = rx_meta_q;
    div_eff   = (baud_div == '0) ? DIV_W'(1) : baud_div;
    tick      = (tcnt_q >= div_q - DIV_W'(1));
    tcnt_d    = tcnt_q + DIV_W'(1);
    div_d     = div_q;
    // The divisor is only reloaded on wrap so a change never shortens a tick
    if (tick) begin
      tcnt_d = '0;
      div_d  = div_eff;
    end
  end

  rx_state_e     state_q;
  logic [SW-1:0] s_q;
  logic [3:0]    n_q;
  logic [DBIT-1:0] sh_q;
  logic          pbit_q, ferr_q, hold_q, push_q, brk_q;
  logic [FW-1:0] word_q;
  logic          stop_ferr, perr_calc, brk_calc;

  always_comb begin
    stop_ferr = ferr_q | ~rxs_q;
    if (PMODE == PAR_EVEN)     perr_calc = (^sh_q) ^ pbit_q;
    else if (PMODE == PAR_ODD) perr_calc = ~((^sh_q) ^ pbit_q);
    else                       perr_calc = 1'b0;
    brk_calc = stop_ferr && (sh_q == '0) && ((PMODE == PAR_NONE) || !pbit_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      pbit_q  <= 1'b0;
      ferr_q  <= 1'b0;
      hold_q  <= 1'b0;
      push_q  <= 1'b0;
      brk_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      push_q <= 1'b0;
      brk_q  <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            // After a framing error the line must go high before a new start
            if (rxs_q) hold_q <= 1'b0;
            else if (!hold_q) begin
              state_q <= START;
              s_q     <= '0;
            end
          end
          START: begin
            if (s_q == SW'(OVS/2-1)) begin
              s_q <= '0;
              if (rxs_q) state_q <= IDLE;
              else begin
                state_q <= DATA;
                n_q     <= '0;
                ferr_q  <= 1'b0;
              end
            end else s_q <= s_q + SW'(1);
          end
          DATA: begin
            if (s_q == SW'(OVS-1)) begin
              s_q  <= '0;
              sh_q <= {rxs_q, sh_q[DBIT-1:1]};
              if (n_q == 4'(DBIT-1)) begin
                n_q     <= '0;
                state_q <= (PMODE != PAR_NONE) ? PARITY : STOP;
              end else n_q <= n_q + 4'd1;
            end else s_q <= s_q + SW'(1);
          end
          PARITY: begin
            if (s_q == SW'(OVS-1)) begin
              s_q     <= '0;
              pbit_q  <= rxs_q;
              state_q <= STOP;
            end else s_q <= s_q + SW'(1);
          end
          STOP: begin
            if (s_q == SW'(OVS-1)) begin
              s_q    <= '0;
              ferr_q <= stop_ferr;
              if (n_q == 4'(SBIT-1)) begin
                n_q     <= '0;
                state_q <= IDLE;
                push_q  <= 1'b1;
                brk_q   <= brk_calc;
                hold_q  <= stop_ferr;
                word_q  <= {stop_ferr, perr_calc, sh_q};
              end else n_q <= n_q + 4'd1;
            end else s_q <= s_q + SW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [FW-1:0] f_rdata;
  logic          f_empty, f_full;
  logic [W:0]    f_count;
  logic          ovr_q, ovr_d;

  sync_fifo_fwft #(.WIDTH(FW), .W(W)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (push_q),
    .rd     (bus.rd),
    .w_data (word_q),
    .r_data (f_rdata),
    .empty  (f_empty),
    .full   (f_full),
    .count  (f_count)
  );

  always_comb begin
    ovr_d = ovr_q;
    if (bus.clr_ovr) ovr_d = 1'b0;
    if (push_q && f_full && !bus.rd) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      div_q     <= DIV_W'(1);
      tcnt_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rxs_q     <= rxs_d;
      div_q     <= div_d;
      tcnt_q    <= tcnt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.r_data    = f_rdata[DBIT-1:0];
  assign bus.r_perr    = f_rdata[DBIT];
  assign bus.r_ferr    = f_rdata[DBIT+1];
  assign bus.empty     = f_empty;
  assign bus.full      = f_full;
  assign bus.count     = f_count;
  assign bus.overrun   = ovr_q;
  assign bus.break_det = brk_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo_cfg.sv
// ============================================================================
// Module      : tb_uart_rx_fifo_cfg
// Description : Self-checking bench: plain 8N1 receiver and an 8E2 receiver,
//               both OVS=4, against a queue-based model of the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_fifo_cfg;

  localparam int OVS   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx0, rx1;
  logic [15:0] div0, div1;

  always #5 clk = ~clk;

  uart_rx_fifo_cfg_if #(.DBIT(8), .W(2)) bus0 ();
  uart_rx_fifo_cfg_if #(.DBIT(8), .W(2)) bus1 ();

  uart_rx_fifo_cfg #(.DBIT(8), .PMODE(0), .SBIT(1), .OVS(OVS), .DIV_W(16), .W(2)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .baud_div(div0), .bus(bus0));

  uart_rx_fifo_cfg #(.DBIT(8), .PMODE(1), .SBIT(2), .OVS(OVS), .DIV_W(16), .W(2)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .baud_div(div1), .bus(bus1));

  int tests = 0;
  int fails = 0;
  int brk_cnt = 0;

  always @(negedge clk) if (bus1.break_det === 1'b1) brk_cnt++;

  // Reference model for the plain receiver: queue of received bytes
  logic [7:0] q0[$];
  logic       ovr_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_clks(input logic [15:0] d);
    return OVS * ((d == 16'd0) ? 1 : int'(d));
  endfunction

  task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
    int bc;
    bc = bit_clks(sel == 0 ? div0 : div1);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx0 = bits[i]; else rx1 = bits[i];
      clks(bc);
    end
    if (sel == 0) rx0 = 1'b1; else rx1 = 1'b1;
    clks(bc);
  endtask

  task automatic send0(input logic [7:0] d);
    send_bits(0, {6'b0, 1'b1, d, 1'b0}, 10);
  endtask

  task automatic send1(input logic [7:0] d, input logic pb, input logic s1, input logic s2);
    send_bits(1, {4'b0, s2, s1, pb, d, 1'b0}, 12);
  endtask

  task automatic model_push(input logic [7:0] d);
    if (q0.size() == DEPTH) ovr_m = 1'b1;
    else q0.push_back(d);
  endtask

  task automatic pop0();
    bus0.rd = 1'b1;
    clks(1);
    bus0.rd = 1'b0;
    if (q0.size() > 0) void'(q0.pop_front());
  endtask

  task automatic check0(input string tag);
    chk({tag, ".count"},   32'(bus0.count),   32'(q0.size()));
    chk({tag, ".empty"},   32'(bus0.empty),   32'(q0.size() == 0));
    chk({tag, ".full"},    32'(bus0.full),    32'(q0.size() == DEPTH));
    chk({tag, ".r_data"},  32'(bus0.r_data),  (q0.size() > 0) ? 32'(q0[0]) : 32'd0);
    chk({tag, ".overrun"}, 32'(bus0.overrun), 32'(ovr_m));
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pb, s1, s2;
    logic       eperr, eferr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] d;
    logic       pb, s1, s2, found;
    int         base;

    // Parity is even; ^07=1, ^3C=0, ^A5=0
    tbl[0] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b0; rx0 = 1'b1; rx1 = 1'b1; div0 = 16'd5; div1 = 16'd5;
    bus0.rd = 1'b0; bus0.clr_ovr = 1'b0; bus1.rd = 1'b0; bus1.clr_ovr = 1'b0;
    ovr_m = 1'b0;
    clks(3);
    check0("reset0");
    chk("reset0.break", 32'(bus0.break_det), 0);
    chk("reset0.perr",  32'(bus0.r_perr), 0);
    chk("reset0.ferr",  32'(bus0.r_ferr), 0);
    chk("reset1.empty", 32'(bus1.empty), 1);
    chk("reset1.count", 32'(bus1.count), 0);
    chk("reset1.break", 32'(bus1.break_det), 0);
    reset = 1'b1;
    clks(5);

    // Reset in the middle of a frame, then a clean frame
    rx0 = 1'b0;
    clks(30);
    reset = 1'b0;
    clks(2);
    reset = 1'b1;
    rx0 = 1'b1;
    clks(40);
    check0("midreset");
    send0(8'h5A); model_push(8'h5A);
    check0("after_reset_5A");
    pop0();

    // Fill to full, overrun, clear, drain
    send0(8'h05); model_push(8'h05);
    send0(8'h06); model_push(8'h06);
    send0(8'h07); model_push(8'h07);
    send0(8'h0F); model_push(8'h0F);
    check0("fill4");
    send0(8'hAA); model_push(8'hAA);
    check0("overrun");
    bus0.clr_ovr = 1'b1; clks(1); bus0.clr_ovr = 1'b0; ovr_m = 1'b0;
    check0("clr_ovr");
    for (int i = 0; i < 4; i++) begin
      pop0();
      check0("drain");
    end

    // Push and pop in the same clock while full
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send0(d); model_push(d);
    end
    check0("refill");
    found = 1'b0;
    fork
      send0(8'hC3);
      begin
        for (int k = 0; k < 400 && !found; k++) begin
          @(posedge clk); #1;
          if (dut0.push_q) found = 1'b1;
        end
        if (found) begin
          bus0.rd = 1'b1;
          clks(1);
          bus0.rd = 1'b0;
        end
      end
    join
    chk("simul.seen", 32'(found), 1);
    void'(q0.pop_front());
    q0.push_back(8'hC3);
    check0("simul");
    while (q0.size() > 0) pop0();
    check0("simul_drain");

    // Short low glitch must not start a frame
    rx0 = 1'b0; clks(int'(div0) * OVS / 4); rx0 = 1'b1;
    clks(60);
    check0("glitch");

    // Divisor 0 behaves like 1
    div0 = 16'd0; clks(20);
    send0(8'h3E); model_push(8'h3E);
    check0("div0");
    pop0();
    div0 = 16'd1; clks(20);
    send0(8'hC1); model_push(8'hC1);
    check0("div1");
    pop0();

    // Random frames, divisors and pops against the model
    for (int it = 0; it < 20; it++) begin
      div0 = 16'($urandom_range(1, 6));
      clks(20);
      d = 8'($urandom_range(0, 255));
      send0(d); model_push(d);
      check0("rand_rx");
      for (int p = $urandom_range(0, 2); p > 0; p--) pop0();
      if ($urandom_range(0, 3) == 0) begin
        bus0.clr_ovr = 1'b1; clks(1); bus0.clr_ovr = 1'b0; ovr_m = 1'b0;
      end
      check0("rand_pop");
    end

    // Parity / framing table on the 8E2 receiver
    for (int i = 0; i < 5; i++) begin
      send1(tbl[i].d, tbl[i].pb, tbl[i].s1, tbl[i].s2);
      chk("tbl.count", 32'(bus1.count),  1);
      chk("tbl.data",  32'(bus1.r_data), 32'(tbl[i].d));
      chk("tbl.perr",  32'(bus1.r_perr), 32'(tbl[i].eperr));
      chk("tbl.ferr",  32'(bus1.r_ferr), 32'(tbl[i].eferr));
      bus1.rd = 1'b1; clks(1); bus1.rd = 1'b0;
      chk("tbl.empty", 32'(bus1.empty), 1);
    end
    chk("tbl.no_break", 32'(brk_cnt), 0);

    // Line held low for two frame times
    base = brk_cnt;
    rx1 = 1'b0;
    clks(2 * 12 * bit_clks(div1));
    chk("break.pulses", 32'(brk_cnt - base), 1);
    chk("break.count",  32'(bus1.count), 1);
    chk("break.data",   32'(bus1.r_data), 0);
    chk("break.ferr",   32'(bus1.r_ferr), 1);
    chk("break.perr",   32'(bus1.r_perr), 0);
    rx1 = 1'b1;
    clks(3 * bit_clks(div1));
    chk("break.after_count",  32'(bus1.count), 1);
    chk("break.after_pulses", 32'(brk_cnt - base), 1);
    bus1.rd = 1'b1; clks(1); bus1.rd = 1'b0;

    // Random 8E2 frames: expected flags from the parity/stop rules
    for (int it = 0; it < 12; it++) begin
      div1 = 16'($urandom_range(2, 6));
      clks(20);
      d  = 8'($urandom_range(1, 255));
      pb = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      send1(d, pb, s1, s2);
      chk("r1.count", 32'(bus1.count),  1);
      chk("r1.data",  32'(bus1.r_data), 32'(d));
      chk("r1.perr",  32'(bus1.r_perr), 32'((^d) ^ pb));
      chk("r1.ferr",  32'(bus1.r_ferr), 32'(!(s1 && s2)));
      bus1.rd = 1'b1; clks(1); bus1.rd = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo_cfg.md
Name: uart_rx_fifo_cfg

Overview:
Parametrised UART receiver with an integrated receive FIFO. It is the successor of the fixed-format receive path and adds the following:
- configurable data bits, parity mode, stop bits and oversampling
- a runtime baud divisor
- per-word parity and framing error flags stored alongside the data
- break detection, sticky overrun, and an occupancy count
It sits between the serial rx pin and the bus-side consumer, and pairs with the transmit FIFO block.

Parameters:
DBIT, 8, data bits per frame (5..9)
PMODE, 0, parity mode: 0 none, 1 even, 2 odd
SBIT, 1, stop bits checked (1 or 2)
OVS, 16, oversampling ticks per bit (even, >=4)
DIV_W, 16, width of the baud divisor
W, 2, FIFO address width; depth = 2**W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
rx  in  1  asynchronous serial input, idle high
baud_div  in  DIV_W  clk cycles per oversample tick; 0 treated as 1
rd  in  1  pop head word (ignored when empty)
clr_ovr  in  1  clear sticky overrun
r_data  out  DBIT  head data (first-word-fall-through); 0 when empty
r_perr  out  1  head word parity error (0 when PMODE=0 or empty)
r_ferr  out  1  head word framing error
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  W+1  words held, 0..2**W
overrun  out  1  sticky: a word arrived while full
break_det  out  1  one-cycle pulse on break frame

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low (reset=0 sampled on the clk edge). Reset is honoured mid-frame: the FSM aborts to IDLE and the FIFO flushes.
- Reset values: empty=1, full=0, count=0, overrun=0, break_det=0, r_data=0, r_perr=0, r_ferr=0; FSM=IDLE; tick counter=0.
- rx synchroniser: rx passes through 2 flops (reset to 1). All logic uses the synchronised value rxs.
- Tick generator: counter runs 0..max(baud_div,1)-1 and pulses tick on wrap. A baud_div change takes effect at the next wrap.
- FSM, advancing on tick only:
  - IDLE: wait for rxs=0 → START, sample counter s=0.
  - START: at s=OVS/2-1, if rxs=1 (glitch) → IDLE; else s=0 → DATA.
  - DATA: sample at s=OVS-1 (mid-bit), shifting LSB first. After DBIT bits → PARITY if PMODE≠0, else → STOP.
  - PARITY: sample at mid-bit. perr = (XOR of data ^ pbit) for even; its inverse for odd.
  - STOP: sample SBIT stop bits at mid-bit. ferr=1 if any sampled stop bit is 0.
  - After the final stop sample → push, then IDLE.
  - If ferr=1, IDLE requires rxs=1 before accepting a new start; a held-low line does not retrigger.
- Break: ferr=1 and data all zero (and parity bit 0 if enabled) → break_det=1 for one clk. The word is still pushed with ferr=1.
- Push: {ferr, perr, data} is written in the clk after the final stop sample. empty falls and count increments in that same clk.
- FIFO:
  - first-word-fall-through; r_* reflect the head combinationally from registered storage.
  - rd pops on the clk edge.
  - rd when empty is ignored.
  - push when full: no write, overrun←1, word dropped.
  - push and rd in the same clk when full: pop then write, count unchanged, no overrun.
  - push and rd in the same clk when empty: the word is written, rd is ignored.
  - Pointers wrap modulo 2**W.
  - full = (count==2**W).
- overrun is cleared by clr_ovr. If clr_ovr and an overrun event coincide, overrun stays set (set wins).

Decomposition:
- Shared package uart_pkg:
  - parity-mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - FSM state encoding IDLE/START/DATA/PARITY/STOP
  - the FIFO word width function DBIT+2
- Natural sub-module: sync_fifo_fwft (parameters width and W; ports wr, rd, w_data, r_data, empty, full, count). The receive FSM and tick generator stay in the top module.

Test Plan:
- Reset=0 for 2 clk mid-frame, then release → empty=1, count=0, overrun=0; the next clean frame 0x5A is received correctly.
- Setup: baud_div=5, OVS=4, PMODE=0, SBIT=1. Frames 0x05, 0x06, 0x07, 0x0F sent → count=4, full=1, r_data=0x05. Four pops then return 0x06, 0x07, 0x0F, and empty=1 after the last.
- Fifth frame 0xAA sent while full → overrun=1, FIFO contents unchanged. clr_ovr pulse → overrun=0.
- PMODE=1: frame 0x07 with parity bit 0 → r_perr=1. Frame 0x07 with parity bit 1 → r_perr=0.
- SBIT=2: second stop bit driven low on 0x3C → r_ferr=1. Line held low for 2 frame times → one break_det pulse, one word 0x00 with ferr=1, no further pushes until rx returns high.
- Glitch: rx low for OVS/4 ticks → nothing pushed. baud_div=0 behaves as baud_div=1. Simultaneous push and rd at full → count stays 4.
